// File: rtl/lsu.sv
// Memory-access stage of the NPC multicycle core.
// Takes one bundle from EXU and runs any load/store over a valid/ready
// data bus. It then sends the writeback bundle to WBU as a one-cycle
// send_valid pulse. WBU has no back-pressure.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    // EXU side
    input  logic            receive_valid,
    output logic            receive_ready,
    input  logic            mem_ren,
    input  logic            mem_wen,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_i,
    input  logic            reg_en_i,
    input  logic [1:0]      csr_rd_i,
    input  logic [XLEN-1:0] csr_wd_i,
    input  logic            csreg_en_i,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_next_i,
    input  logic [XLEN-1:0] instruction_i,

    // WBU side
    output logic            send_valid,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wd,
    output logic            reg_en,
    output logic [1:0]      csr_rd,
    output logic [XLEN-1:0] csr_wd,
    output logic            csreg_en,
    output logic            ecall,
    output logic            ebreak,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] instruction,

    // Data-memory bus
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        is_load_q;

    logic [3:0]      st_strb;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_value;

    // Select the load lane and extend it. funct3 codes outside the table read the whole word.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*off +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
            3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
            3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
            default: load_extract = rdata;
        endcase
    endfunction

    // Store lane placement, computed from the incoming bundle at acceptance
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = store_data;
        case (funct3)
            3'b000: begin
                st_strb  = 4'b0001 << alu_result[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            3'b001: begin
                st_strb  = 4'b0011 << {alu_result[1], 1'b0};
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Extracted load value from the current response word
    always_comb begin
        ld_value = load_extract(funct3_q, off_q, mem_rdata);
    end

    // Control FSM with registered handshake, bus and writeback outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            receive_ready <= 1'b1;
            send_valid    <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            is_load_q     <= 1'b0;
            rd            <= '0;
            wd            <= '0;
            reg_en        <= 1'b0;
            csr_rd        <= '0;
            csr_wd        <= '0;
            csreg_en      <= 1'b0;
            ecall         <= 1'b0;
            ebreak        <= 1'b0;
            pc            <= '0;
            pc_next       <= '0;
            instruction   <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    send_valid <= 1'b0;
                    if (receive_valid) begin
                        receive_ready <= 1'b0;
                        rd            <= rd_i;
                        wd            <= alu_result;
                        reg_en        <= reg_en_i;
                        csr_rd        <= csr_rd_i;
                        csr_wd        <= csr_wd_i;
                        csreg_en      <= csreg_en_i;
                        ecall         <= ecall_i;
                        ebreak        <= ebreak_i;
                        pc            <= pc_i;
                        pc_next       <= pc_next_i;
                        instruction   <= instruction_i;
                        funct3_q      <= funct3;
                        off_q         <= alu_result[1:0];
                        is_load_q     <= mem_ren;
                        if (mem_ren || mem_wen) begin
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {alu_result[XLEN-1:2], 2'b00};
                            mem_we        <= mem_wen;
                            mem_wdata     <= mem_wen ? st_wdata : '0;
                            mem_wstrb     <= mem_wen ? st_strb : '0;
                            state         <= REQ;
                        end else begin
                            send_valid <= 1'b1;
                            state      <= SEND;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (is_load_q) begin
                            wd <= ld_value;
                        end
                        send_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    send_valid    <= 1'b0;
                    receive_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    send_valid    <= 1'b0;
                    mem_req_valid <= 1'b0;
                    receive_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-written
// multi-cycle sequences, and random transactions checked against a
// reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        receive_valid, receive_ready;
    logic        mem_ren, mem_wen;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd_i;
    logic        reg_en_i;
    logic [1:0]  csr_rd_i;
    logic [31:0] csr_wd_i;
    logic        csreg_en_i, ecall_i, ebreak_i;
    logic [31:0] pc_i, pc_next_i, instruction_i;
    logic        send_valid;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        reg_en;
    logic [1:0]  csr_rd;
    logic [31:0] csr_wd;
    logic        csreg_en, ecall, ebreak;
    logic [31:0] pc, pc_next, instruction;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .receive_valid(receive_valid), .receive_ready(receive_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data),
        .rd_i(rd_i), .reg_en_i(reg_en_i), .csr_rd_i(csr_rd_i), .csr_wd_i(csr_wd_i),
        .csreg_en_i(csreg_en_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i),
        .pc_i(pc_i), .pc_next_i(pc_next_i), .instruction_i(instruction_i),
        .send_valid(send_valid), .rd(rd), .wd(wd), .reg_en(reg_en),
        .csr_rd(csr_rd), .csr_wd(csr_wd), .csreg_en(csreg_en),
        .ecall(ecall), .ebreak(ebreak), .pc(pc), .pc_next(pc_next),
        .instruction(instruction),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        bit          ren;
        bit          wen;
        bit [2:0]    f3;
        bit [31:0]   addr;
        bit [31:0]   sd;
        bit [31:0]   rdata;
        bit [31:0]   exp_addr;
        bit [31:0]   exp_wdata;
        bit [3:0]    exp_strb;
        bit [31:0]   exp_wd;
        int          stall;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: loads pick a lane by shifting and extend by arithmetic
    function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] addr,
                                           input bit [31:0] rdata);
        int unsigned off = addr % 4;
        bit [31:0] b = (rdata >> (8 * off)) & 32'hFF;
        bit [31:0] h = (rdata >> (8 * (off / 2) * 2)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic bit [3:0] ref_strb(input bit [2:0] f3, input bit [31:0] addr);
        int unsigned off = addr % 4;
        case (f3)
            3'd0:    return 4'(1 << off);
            3'd1:    return 4'(3 << ((off / 2) * 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic bit [31:0] ref_wdata(input bit [2:0] f3, input bit [31:0] sd);
        case (f3)
            3'd0:    return (sd & 32'hFF) * 32'h01010101;
            3'd1:    return (sd & 32'hFFFF) * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    task automatic idle_inputs();
        receive_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = $urandom;
    endtask

    // Runs one transaction end to end and checks every visible step
    task automatic run_txn(input vec_t v);
        bit [4:0]  erd  = 5'($urandom);
        bit [31:0] epc  = $urandom;
        bit [31:0] eins = $urandom;
        bit        ereg = 1'($urandom);
        bit        got_ready = 0;
        mem_ren       = v.ren;
        mem_wen       = v.wen;
        funct3        = v.f3;
        alu_result    = v.addr;
        store_data    = v.sd;
        rd_i          = erd;
        reg_en_i      = ereg;
        pc_i          = epc;
        instruction_i = eins;
        pc_next_i     = epc + 4;
        receive_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (receive_ready) begin got_ready = 1; break; end
            @(negedge clk);
        end
        if (!got_ready) begin
            chk({v.name, "_ready_timeout"}, 0, 1);
            receive_valid = 1'b0;
            return;
        end
        @(negedge clk);
        receive_valid = 1'b0;
        alu_result    = $urandom;
        store_data    = $urandom;
        rd_i          = 5'($urandom);
        pc_i          = $urandom;
        chk({v.name, "_ready_low"}, receive_ready, 0);
        if (v.ren || v.wen) begin
            chk({v.name, "_req_valid"}, mem_req_valid, 1);
            chk({v.name, "_addr"}, mem_addr, v.exp_addr);
            chk({v.name, "_we"}, mem_we, v.wen);
            chk({v.name, "_wdata"}, mem_wdata, v.exp_wdata);
            chk({v.name, "_wstrb"}, mem_wstrb, v.exp_strb);
            for (int s = 0; s < v.stall; s++) begin
                mem_resp_valid = 1'b1;
                @(negedge clk);
                chk({v.name, "_stall_valid"}, mem_req_valid, 1);
                chk({v.name, "_stall_addr"}, mem_addr, v.exp_addr);
                chk({v.name, "_stall_wdata"}, mem_wdata, v.exp_wdata);
                chk({v.name, "_stall_wstrb"}, mem_wstrb, v.exp_strb);
                chk({v.name, "_stall_send"}, send_valid, 0);
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk({v.name, "_req_dropped"}, mem_req_valid, 0);
            chk({v.name, "_send_early"}, send_valid, 0);
            for (int l = 0; l < v.lat; l++) begin
                @(negedge clk);
                chk({v.name, "_wait_send"}, send_valid, 0);
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = v.rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_rdata      = $urandom;
        end
        chk({v.name, "_send"}, send_valid, 1);
        if (!v.wen) chk({v.name, "_wd"}, wd, v.exp_wd);
        chk({v.name, "_rd"}, rd, erd);
        chk({v.name, "_reg_en"}, reg_en, ereg);
        chk({v.name, "_pc"}, pc, epc);
        chk({v.name, "_instr"}, instruction, eins);
        @(negedge clk);
        chk({v.name, "_send_off"}, send_valid, 0);
        chk({v.name, "_ready_back"}, receive_ready, 1);
    endtask

    vec_t vecs[$];
    vec_t v;
    bit [31:0] hold_wd;

    initial begin
        rst = 1'b1;
        mem_ren = 0; mem_wen = 0; funct3 = 0; alu_result = 0; store_data = 0;
        rd_i = 0; reg_en_i = 0; csr_rd_i = 0; csr_wd_i = 0; csreg_en_i = 0;
        ecall_i = 0; ebreak_i = 0; pc_i = 0; pc_next_i = 0; instruction_i = 0;
        idle_inputs();

        //           name     ren wen f3    addr          sd            rdata         exp_addr      exp_wdata     strb     exp_wd        stall lat
        vecs.push_back('{"alu",  0, 0, 3'd0, 32'h00001234, 32'h0,        32'h0,        32'h0,        32'h0,        4'h0,    32'h00001234, 0, 0});
        vecs.push_back('{"lbu",  1, 0, 3'd4, 32'h80000003, 32'h0,        32'hA1B2C3D4, 32'h80000000, 32'h0,        4'h0,    32'h000000A1, 0, 0});
        vecs.push_back('{"lb",   1, 0, 3'd0, 32'h80000003, 32'h0,        32'hA1B2C3D4, 32'h80000000, 32'h0,        4'h0,    32'hFFFFFFA1, 1, 1});
        vecs.push_back('{"lh",   1, 0, 3'd1, 32'h80000002, 32'h0,        32'h80017FFF, 32'h80000000, 32'h0,        4'h0,    32'hFFFF8001, 0, 2});
        vecs.push_back('{"lhu",  1, 0, 3'd5, 32'h80000002, 32'h0,        32'h80017FFF, 32'h80000000, 32'h0,        4'h0,    32'h00008001, 0, 0});
        vecs.push_back('{"lh_o1",1, 0, 3'd1, 32'h80000001, 32'h0,        32'h1234ABCD, 32'h80000000, 32'h0,        4'h0,    32'hFFFFABCD, 0, 0});
        vecs.push_back('{"lw",   1, 0, 3'd2, 32'h80000006, 32'h0,        32'hDEADBEEF, 32'h80000004, 32'h0,        4'h0,    32'hDEADBEEF, 0, 0});
        vecs.push_back('{"l_f3x",1, 0, 3'd3, 32'h00000011, 32'h0,        32'h89ABCDEF, 32'h00000010, 32'h0,        4'h0,    32'h89ABCDEF, 0, 0});
        vecs.push_back('{"sb",   0, 1, 3'd0, 32'h80000001, 32'h11223344, 32'h0,        32'h80000000, 32'h44444444, 4'b0010, 32'h0,        3, 0});
        vecs.push_back('{"sh",   0, 1, 3'd1, 32'h80000003, 32'h0000ABCD, 32'h0,        32'h80000000, 32'hABCDABCD, 4'b1100, 32'h0,        0, 1});
        vecs.push_back('{"sw",   0, 1, 3'd2, 32'h00000010, 32'hCAFEF00D, 32'h0,        32'h00000010, 32'hCAFEF00D, 4'b1111, 32'h0,        2, 0});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_send", send_valid, 0);
        chk("rst_req", mem_req_valid, 0);
        chk("rst_wd", wd, 0);
        chk("rst_rd", rd, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ready", receive_ready, 1);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Back-to-back: second bundle held while busy must wait for SEND to finish
        mem_ren = 0; mem_wen = 0; alu_result = 32'h0000AAAA; rd_i = 5'd7;
        receive_valid = 1'b1;
        @(negedge clk);
        alu_result = 32'h0000BBBB; rd_i = 5'd9;
        chk("b2b_send1", send_valid, 1);
        chk("b2b_wd1", wd, 32'h0000AAAA);
        chk("b2b_ready_busy", receive_ready, 0);
        @(negedge clk);
        chk("b2b_gap_send", send_valid, 0);
        chk("b2b_hold_wd", wd, 32'h0000AAAA);
        chk("b2b_hold_rd", rd, 7);
        chk("b2b_ready", receive_ready, 1);
        @(negedge clk);
        receive_valid = 1'b0;
        chk("b2b_send2", send_valid, 1);
        chk("b2b_wd2", wd, 32'h0000BBBB);
        chk("b2b_rd2", rd, 9);
        @(negedge clk);
        chk("b2b_send2_off", send_valid, 0);
        hold_wd = wd;
        @(negedge clk);
        chk("b2b_idle_hold", wd, hold_wd);

        // Reset while waiting for a response, then a late response in IDLE
        mem_ren = 1; mem_wen = 0; funct3 = 3'd2; alu_result = 32'h00000100; rd_i = 5'd3;
        receive_valid = 1'b1;
        @(negedge clk);
        receive_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rstw_in_wait", mem_req_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("rstw_send", send_valid, 0);
        chk("rstw_wd", wd, 0);
        chk("rstw_rd", rd, 0);
        chk("rstw_req", mem_req_valid, 0);
        chk("rstw_addr", mem_addr, 0);
        chk("rstw_ready", receive_ready, 1);
        @(negedge clk);
        chk("rstw_send_later", send_valid, 0);
        mem_ren = 0;

        // Random transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            int unsigned kind = $urandom_range(0, 2);
            v.name      = "rnd";
            v.ren       = (kind == 1);
            v.wen       = (kind == 2);
            v.f3        = 3'($urandom_range(0, 7));
            v.addr      = $urandom;
            v.sd        = $urandom;
            v.rdata     = $urandom;
            v.exp_addr  = v.addr - (v.addr % 4);
            v.exp_wdata = v.wen ? ref_wdata(v.f3, v.sd) : 32'h0;
            v.exp_strb  = v.wen ? ref_strb(v.f3, v.addr) : 4'h0;
            v.exp_wd    = v.ren ? ref_load(v.f3, v.addr, v.rdata) : v.addr;
            v.stall     = $urandom_range(0, 3);
            v.lat       = $urandom_range(0, 2);
            run_txn(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
